fetch_ctrl: RTL and testbench

Instruction-fetch sequencer for the pipelined MIPS core. Owns the architectural PC register and drives the instruction-memory request/acknowledge handshake. Resolves pipeline stalls from the hazard unit and branch/jump redirects from the control unit, including redirects that arrive while a fetch is still outstanding. Presents a single-entry fetched-instruction slot (address + valid) to the IF/ID stage; the next address is always PC+4 unless a redirect is pending.

---
 rtl/fetch_ctrl_if.sv | 42 ++++
 rtl/fetch_ctrl.sv | 126 ++++++++++++
 tb/tb_fetch_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
//------------------------------------------------------------------------------
// fetch_ctrl_if : fetch-sequencer control and instruction-memory signal bundle
// Rev 1.0 ; misalign_o present only with FETCH_MISALIGN_CHK_EN
//------------------------------------------------------------------------------
`default_nettype none

`ifndef InstAddrBus
`define InstAddrBus 31:0
`endif

interface fetch_ctrl_if;
  logic               stall_i;
  logic               branch_i;
  logic [`InstAddrBus] jump_addr_i;
  logic               imem_ack_i;
  logic               imem_req_o;
  logic [`InstAddrBus] imem_addr_o;
  logic               if_valid_o;
  logic [`InstAddrBus] if_pc_o;
  logic [`InstAddrBus] pc_plus_4_o;
`ifdef FETCH_MISALIGN_CHK_EN
  logic               misalign_o;
`endif

  modport master (
    input  stall_i, branch_i, jump_addr_i, imem_ack_i,
`ifdef FETCH_MISALIGN_CHK_EN
    output misalign_o,
`endif
    output imem_req_o, imem_addr_o, if_valid_o, if_pc_o, pc_plus_4_o
  );

  modport slave (
    output stall_i, branch_i, jump_addr_i, imem_ack_i,
`ifdef FETCH_MISALIGN_CHK_EN
    input  misalign_o,
`endif
    input  imem_req_o, imem_addr_o, if_valid_o, if_pc_o, pc_plus_4_o
  );
endinterface

`default_nettype wire

// File: rtl/fetch_ctrl.sv
//------------------------------------------------------------------------------
// fetch_ctrl : instruction-fetch sequencer (PC, imem handshake, redirects)
// Rev 1.0 ; optional misaligned-target trap via FETCH_MISALIGN_CHK_EN
//------------------------------------------------------------------------------
`default_nettype none

`ifndef InstAddrBus
`define InstAddrBus 31:0
`endif

module fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
`ifdef FETCH_MISALIGN_CHK_EN
  , parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
`endif
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  fetch_ctrl_if.master     bus
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2,
    S_DROP  = 2'd3
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] tgt_q;
  logic [31:0] if_pc_q;
  logic        valid_q;
  logic        w_req;
  logic [31:0] w_target;

`ifdef FETCH_MISALIGN_CHK_EN
  logic        misalign_q;
  logic        w_mis;

  assign w_mis    = bus.branch_i & (|bus.jump_addr_i[1:0]);
  assign w_target = w_mis ? EXC_VECTOR : (bus.jump_addr_i & ~32'h3);
  assign bus.misalign_o = misalign_q;
`else
  assign w_target = bus.jump_addr_i & ~32'h3;
`endif

  // WAIT/DROP keep the outstanding request asserted until it is acknowledged.
  always_comb begin
    w_req = 1'b0;
    unique case (state_q)
      S_FETCH:        w_req = !bus.branch_i & (!valid_q | !bus.stall_i);
      S_WAIT, S_DROP: w_req = 1'b1;
      default:        w_req = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      tgt_q      <= 32'h0;
      if_pc_q    <= 32'h0;
      valid_q    <= 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
`ifdef FETCH_MISALIGN_CHK_EN
      misalign_q <= w_mis;
`endif
      if (!bus.stall_i) valid_q <= 1'b0;
      unique case (state_q)
        S_BOOT: state_q <= S_FETCH;
        S_FETCH: begin
          if (bus.branch_i) begin
            pc_q <= w_target;
          end else if (w_req) begin
            if (bus.imem_ack_i) begin
              if_pc_q <= pc_q;
              valid_q <= 1'b1;
              pc_q    <= pc_q + 32'd4;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (bus.imem_ack_i) begin
            if (bus.branch_i) begin
              pc_q <= w_target;
            end else begin
              if_pc_q <= pc_q;
              valid_q <= 1'b1;
              pc_q    <= pc_q + 32'd4;
            end
            state_q <= S_FETCH;
          end else if (bus.branch_i) begin
            tgt_q   <= w_target;
            state_q <= S_DROP;
          end
        end
        S_DROP: begin
          // Old request's data is wrong-path; the latest redirect wins.
          if (bus.imem_ack_i) begin
            pc_q    <= bus.branch_i ? w_target : tgt_q;
            state_q <= S_FETCH;
          end else if (bus.branch_i) begin
            tgt_q <= w_target;
          end
        end
        default: state_q <= S_BOOT;
      endcase
      if (bus.branch_i) valid_q <= 1'b0;
    end
  end

  assign bus.imem_req_o  = w_req;
  assign bus.imem_addr_o = pc_q;
  assign bus.if_valid_o  = valid_q;
  assign bus.if_pc_o     = if_pc_q;
  assign bus.pc_plus_4_o = if_pc_q + 32'd4;

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
//------------------------------------------------------------------------------
// tb_fetch_ctrl : directed self-checking bench for fetch_ctrl
// Rev 1.0 ; expectations follow FETCH_MISALIGN_CHK_EN when defined
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_ctrl;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  fetch_ctrl_if u_if ();

  fetch_ctrl u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef FETCH_MISALIGN_CHK_EN
  localparam logic [31:0] c_MIS_TGT = 32'h0000_0180;
`else
  localparam logic [31:0] c_MIS_TGT = 32'h0000_0100;
`endif

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic slot(input string tag, input logic v, input logic [31:0] pc);
    check_val({tag, "_valid"}, {31'h0, u_if.if_valid_o}, {31'h0, v});
    if (v) check_val({tag, "_ifpc"}, u_if.if_pc_o, pc);
  endtask

  task automatic req(input string tag, input logic r, input logic [31:0] a);
    check_val({tag, "_req"}, {31'h0, u_if.imem_req_o}, {31'h0, r});
    check_val({tag, "_addr"}, u_if.imem_addr_o, a);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    u_if.stall_i = 1'b0;
    u_if.branch_i = 1'b0;
    u_if.jump_addr_i = 32'h0;
    u_if.imem_ack_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    req("rst", 1'b0, 32'h0);
    slot("rst", 1'b0, 32'h0);
    check_val("rst_ifpc", u_if.if_pc_o, 32'h0);
`ifdef FETCH_MISALIGN_CHK_EN
    check_val("rst_mis", {31'h0, u_if.misalign_o}, 32'h0);
`endif

    // Streaming with zero-wait memory
    @(negedge clk); rst_n = 1'b1; u_if.imem_ack_i = 1'b1; #1;
    req("boot", 1'b0, 32'h0);
    @(negedge clk); #1;
    req("first", 1'b1, 32'h0);
    slot("first", 1'b0, 32'h0);
    @(negedge clk); #1;
    slot("s0", 1'b1, 32'h0);
    check_val("s0_p4", u_if.pc_plus_4_o, 32'h4);
    req("s0", 1'b1, 32'h4);
    @(negedge clk); #1;
    slot("s1", 1'b1, 32'h4);
    check_val("s1_p4", u_if.pc_plus_4_o, 32'h8);

    // Stall holds slot 0x8 for three cycles
    @(negedge clk); u_if.stall_i = 1'b1; #1;
    slot("st0", 1'b1, 32'h8);
    req("st0", 1'b0, 32'hC);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      slot("st", 1'b1, 32'h8);
      req("st", 1'b0, 32'hC);
    end
    @(negedge clk); u_if.stall_i = 1'b0; #1;
    req("resume", 1'b1, 32'hC);
    @(negedge clk); u_if.imem_ack_i = 1'b0; #1;
    slot("resume", 1'b1, 32'hC);
    req("w0", 1'b1, 32'h10);

    // Redirect while waiting on 0x10
    @(negedge clk); #1;
    req("w1", 1'b1, 32'h10);
    slot("w1", 1'b0, 32'h0);
    @(negedge clk); u_if.branch_i = 1'b1; u_if.jump_addr_i = 32'h100; #1;
    req("w2", 1'b1, 32'h10);
    @(negedge clk); u_if.branch_i = 1'b0; u_if.imem_ack_i = 1'b1; #1;
    req("drop", 1'b1, 32'h10);
    slot("drop", 1'b0, 32'h0);
    @(negedge clk); #1;
    req("redir", 1'b1, 32'h100);
    slot("redir", 1'b0, 32'h0);

    // Branch coincident with ack in WAIT
    @(negedge clk); u_if.branch_i = 1'b1; u_if.jump_addr_i = 32'h20; #1;
    slot("b100", 1'b1, 32'h100);
    check_val("br_noreq", {31'h0, u_if.imem_req_o}, 32'h0);
    @(negedge clk); u_if.branch_i = 1'b0; u_if.imem_ack_i = 1'b0; #1;
    req("a20", 1'b1, 32'h20);
    slot("a20", 1'b0, 32'h0);
    @(negedge clk); u_if.imem_ack_i = 1'b1; u_if.branch_i = 1'b1; u_if.jump_addr_i = 32'h200; #1;
    req("w20", 1'b1, 32'h20);
    @(negedge clk); u_if.branch_i = 1'b0; #1;
    slot("disc20", 1'b0, 32'h0);
    req("a200", 1'b1, 32'h200);

    // PC wrap-around
    @(negedge clk); u_if.branch_i = 1'b1; u_if.jump_addr_i = 32'hFFFF_FFFC; #1;
    slot("v200", 1'b1, 32'h200);
    @(negedge clk); u_if.branch_i = 1'b0; #1;
    req("top", 1'b1, 32'hFFFF_FFFC);
    @(negedge clk); u_if.branch_i = 1'b1; u_if.jump_addr_i = 32'h102; #1;
    slot("top", 1'b1, 32'hFFFF_FFFC);
    check_val("wrap_p4", u_if.pc_plus_4_o, 32'h0);
    check_val("wrap_addr", u_if.imem_addr_o, 32'h0);

    // Misaligned target
    @(negedge clk); u_if.branch_i = 1'b0; #1;
    req("mis", 1'b1, c_MIS_TGT);
`ifdef FETCH_MISALIGN_CHK_EN
    check_val("mis_pulse", {31'h0, u_if.misalign_o}, 32'h1);
`endif
    @(negedge clk); u_if.imem_ack_i = 1'b0; #1;
    slot("mis", 1'b1, c_MIS_TGT);
`ifdef FETCH_MISALIGN_CHK_EN
    check_val("mis_end", {31'h0, u_if.misalign_o}, 32'h0);
`endif

    // Reset during an outstanding request, late ack in BOOT
    @(negedge clk); rst_n = 1'b0; #1;
    req("arst", 1'b0, 32'h0);
    slot("arst", 1'b0, 32'h0);
    @(negedge clk); u_if.imem_ack_i = 1'b1; rst_n = 1'b1; #1;
    req("late", 1'b0, 32'h0);
    @(negedge clk); #1;
    slot("late", 1'b0, 32'h0);
    req("reboot", 1'b1, 32'h0);
    @(negedge clk); #1;
    slot("reboot", 1'b1, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
